// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the reg_file_rd register file.
// The default configuration (4-bit entries, 8 entries) is captured here so that
// the top-level parameters and the testbench start from one definition.
package reg_file_pkg;

  localparam int unsigned DEF_BITS    = 4;
  localparam int unsigned DEF_ENTRIES = 8;

  // Address width for a given entry count; keeps one bit for the degenerate case.
  function automatic int unsigned addr_w(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  localparam int unsigned ADDR_W = addr_w(DEF_ENTRIES);

  typedef logic [DEF_BITS-1:0] data_t;
  typedef logic [ADDR_W-1:0]   addr_t;

  // One read request as seen by a read port.
  typedef struct packed {
    logic  en;
    addr_t addr;
  } read_req_t;

endpackage

// File: rtl/reg_file_rd_if.sv
// Bus interface of reg_file_rd: one write port and two read ports (A, B).
// master: the pipeline side (decode issues reads, writeback issues writes).
// slave : the register file.
interface reg_file_rd_if #(
  parameter int unsigned BITS    = reg_file_pkg::DEF_BITS,
  parameter int unsigned ENTRIES = reg_file_pkg::DEF_ENTRIES
);

  localparam int unsigned ADDR_W = reg_file_pkg::addr_w(ENTRIES);

  logic              wenable;
  logic [ADDR_W-1:0] waddr;
  logic [BITS-1:0]   wdata;

  logic              renable_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [BITS-1:0]   rdata_a;
  logic              rvalid_a;

  logic              renable_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [BITS-1:0]   rdata_b;
  logic              rvalid_b;

  modport master (
    output wenable, waddr, wdata,
    output renable_a, raddr_a, renable_b, raddr_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  wenable, waddr, wdata,
    input  renable_a, raddr_a, renable_b, raddr_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b
  );

endinterface

// File: rtl/reg_read_port.sv
// One registered read port of the register file.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   entries_i         flattened storage array, entry n at [n*BITS +: BITS]
//   wenable_i/waddr_i/wdata_i  current-cycle write, used for write-first bypass
//   renable_i/raddr_i read request
//   rdata_o/rvalid_o  registered read data and one-cycle valid strobe
module reg_read_port #(
  parameter int unsigned BITS     = 4,
  parameter int unsigned ENTRIES  = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ENTRIES*BITS-1:0] entries_i,
  input  logic                    wenable_i,
  input  logic [ADDR_W-1:0]       waddr_i,
  input  logic [BITS-1:0]         wdata_i,
  input  logic                    renable_i,
  input  logic [ADDR_W-1:0]       raddr_i,
  output logic [BITS-1:0]         rdata_o,
  output logic                    rvalid_o
);

  logic [BITS-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic [BITS-1:0] entry_sel;
  logic            addr_is_zero;

  assign entry_sel    = entries_i[raddr_i*BITS +: BITS];
  assign addr_is_zero = (raddr_i == '0);

  // Next read data: zero-reg override beats bypass, bypass beats storage.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (renable_i) begin
      rvalid_d = 1'b1;
      if (ZERO_REG && addr_is_zero) begin
        rdata_d = '0;
      end else if (wenable_i && (waddr_i == raddr_i)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = entry_sel;
      end
    end
  end

  // Output registers; a request in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/reg_file_rd.sv
// Register file with one write port and two independent registered read ports.
// Reads have one cycle of latency and see same-cycle writes (write-first).
// With ZERO_REG set, entry 0 is hard-wired to zero.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   rf        reg_file_rd_if slave: write port, read ports A and B
module reg_file_rd
  import reg_file_pkg::*;
#(
  parameter int unsigned BITS     = DEF_BITS,
  parameter int unsigned ENTRIES  = DEF_ENTRIES,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_rd_if.slave rf
);

  localparam int unsigned AW = addr_w(ENTRIES);

  logic [ENTRIES-1:0][BITS-1:0] mem_q, mem_d;
  logic                         wr_ok;

  // Writes to entry 0 are dropped when it is the zero register.
  assign wr_ok = rf.wenable && !(ZERO_REG && (rf.waddr == '0));

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[rf.waddr] = rf.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  reg_read_port #(
    .BITS     (BITS),
    .ENTRIES  (ENTRIES),
    .ADDR_W   (AW),
    .ZERO_REG (ZERO_REG)
  ) u_port_a (
    .clk       (clk),
    .rst       (rst),
    .entries_i (mem_q),
    .wenable_i (rf.wenable),
    .waddr_i   (rf.waddr),
    .wdata_i   (rf.wdata),
    .renable_i (rf.renable_a),
    .raddr_i   (rf.raddr_a),
    .rdata_o   (rf.rdata_a),
    .rvalid_o  (rf.rvalid_a)
  );

  reg_read_port #(
    .BITS     (BITS),
    .ENTRIES  (ENTRIES),
    .ADDR_W   (AW),
    .ZERO_REG (ZERO_REG)
  ) u_port_b (
    .clk       (clk),
    .rst       (rst),
    .entries_i (mem_q),
    .wenable_i (rf.wenable),
    .waddr_i   (rf.waddr),
    .wdata_i   (rf.wdata),
    .renable_i (rf.renable_b),
    .raddr_i   (rf.raddr_b),
    .rdata_o   (rf.rdata_b),
    .rvalid_o  (rf.rvalid_b)
  );

endmodule

// File: tb/tb_reg_file_rd.sv
// Self-checking bench for reg_file_rd: reference model plus per-port
// expectation queues, directed scenarios followed by random traffic.
module tb_reg_file_rd;
  import reg_file_pkg::*;

  localparam int unsigned BITS    = DEF_BITS;
  localparam int unsigned ENTRIES = DEF_ENTRIES;
  localparam int unsigned AW      = ADDR_W;

  typedef struct {
    logic            v;
    logic [BITS-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_rd_if #(.BITS(BITS), .ENTRIES(ENTRIES)) rf ();

  reg_file_rd #(.BITS(BITS), .ENTRIES(ENTRIES), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  exp_t            qa[$];
  exp_t            qb[$];
  logic [BITS-1:0] mdl [ENTRIES];
  logic [BITS-1:0] last_a, last_b;
  int              checks = 0;
  int              errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference read: write already applied to the model, entry 0 forced to zero.
  function automatic logic [BITS-1:0] mdl_read(input logic [AW-1:0] a);
    return (a == '0) ? '0 : mdl[a];
  endfunction

  // Drive one cycle, predict both ports, then compare after the edge.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [BITS-1:0] wd, input logic ea, input logic [AW-1:0] aa,
                      input logic eb, input logic [AW-1:0] ab);
    exp_t ex_a, ex_b;
    exp_t got_a, got_b;
    @(negedge clk);
    rst          = r;
    rf.wenable   = we;
    rf.waddr     = wa;
    rf.wdata     = wd;
    rf.renable_a = ea;
    rf.raddr_a   = aa;
    rf.renable_b = eb;
    rf.raddr_b   = ab;
    if (r) begin
      for (int i = 0; i < int'(ENTRIES); i++) mdl[i] = '0;
      last_a = '0;
      last_b = '0;
      ex_a.v = 1'b0;
      ex_b.v = 1'b0;
    end else begin
      if (we && (wa != '0)) mdl[wa] = wd;
      if (ea) last_a = mdl_read(aa);
      if (eb) last_b = mdl_read(ab);
      ex_a.v = ea;
      ex_b.v = eb;
    end
    ex_a.d = last_a;
    ex_b.d = last_b;
    qa.push_back(ex_a);
    qb.push_back(ex_b);
    @(posedge clk);
    #1;
    if (qa.size() == 0 || qb.size() == 0) begin
      check("scoreboard_empty", 32'(qa.size()), 32'd1);
    end else begin
      got_a = qa.pop_front();
      got_b = qb.pop_front();
      check("rvalid_a", 32'(rf.rvalid_a), 32'(got_a.v));
      check("rdata_a",  32'(rf.rdata_a),  32'(got_a.d));
      check("rvalid_b", 32'(rf.rvalid_b), 32'(got_b.v));
      check("rdata_b",  32'(rf.rdata_b),  32'(got_b.d));
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [BITS-1:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    rst          = 1'b1;
    rf.wenable   = 1'b0;
    rf.waddr     = '0;
    rf.wdata     = '0;
    rf.renable_a = 1'b0;
    rf.raddr_a   = '0;
    rf.renable_b = 1'b0;
    rf.raddr_b   = '0;
    for (int i = 0; i < int'(ENTRIES); i++) mdl[i] = '0;
    last_a = '0;
    last_b = '0;

    // Reset held for two edges with a pending read on A.
    step(1'b1, 1'b0, '0, '0, 1'b1, AW'(3), 1'b0, '0);
    check("rst_rdata_a",  32'(rf.rdata_a), 32'h0);
    check("rst_rvalid_a", 32'(rf.rvalid_a), 32'h0);
    step(1'b1, 1'b1, AW'(3), 4'hF, 1'b1, AW'(3), 1'b1, AW'(3));
    check("rst2_rvalid_b", 32'(rf.rvalid_b), 32'h0);
    for (int i = 0; i < int'(ENTRIES); i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(int'(ENTRIES) - 1 - i));
    end

    // Write then read, then hold.
    wr(AW'(5), 4'b1010);
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), 1'b0, '0);
    check("wr_rd_5", 32'(rf.rdata_a), 32'hA);
    idle();
    check("hold_5_data",  32'(rf.rdata_a), 32'hA);
    check("hold_5_valid", 32'(rf.rvalid_a), 32'h0);

    // Write-first bypass on port B.
    wr(AW'(2), 4'b0011);
    step(1'b0, 1'b1, AW'(2), 4'b1111, 1'b0, '0, 1'b1, AW'(2));
    check("bypass_b", 32'(rf.rdata_b), 32'hF);

    // Zero register: no write, no bypass.
    step(1'b0, 1'b1, AW'(0), 4'b1111, 1'b1, AW'(0), 1'b0, '0);
    check("zero_bypass", 32'(rf.rdata_a), 32'h0);
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(0), 1'b0, '0);
    check("zero_read", 32'(rf.rdata_a), 32'h0);

    // Dual port, different and same address.
    wr(AW'(4), 4'b0110);
    wr(AW'(7), 4'b1001);
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(4), 1'b1, AW'(7));
    check("dual_a4", 32'(rf.rdata_a), 32'h6);
    check("dual_b7", 32'(rf.rdata_b), 32'h9);
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(7), 1'b1, AW'(7));
    check("same_a7", 32'(rf.rdata_a), 32'h9);
    check("same_b7", 32'(rf.rdata_b), 32'h9);

    // Reset in the middle of traffic.
    wr(AW'(6), 4'b1100);
    step(1'b1, 1'b0, '0, '0, 1'b1, AW'(6), 1'b1, AW'(6));
    check("midrst_data",  32'(rf.rdata_a), 32'h0);
    check("midrst_valid", 32'(rf.rvalid_a), 32'h0);
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(6), 1'b0, '0);
    check("postrst_6", 32'(rf.rdata_a), 32'h0);

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 40) == 0),
           1'($urandom()), AW'($urandom()), BITS'($urandom()),
           1'($urandom()), AW'($urandom()),
           1'($urandom()), AW'($urandom()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
